// File: rtl/sme_pkg.sv
// Shared constants, character codes and FSM state encoding for the SME job loader.
package sme_pkg;

    localparam int unsigned MAX_STR_LEN = 32;
    localparam int unsigned MAX_PAT_LEN = 8;

    localparam logic [7:0] CH_START = 8'h5E;
    localparam logic [7:0] CH_END   = 8'h24;
    localparam logic [7:0] CH_ANY   = 8'h2E;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_H0,
        S_RD_H1,
        S_CHK,
        S_STR,
        S_PAT,
        S_GAP,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    // A header is usable when both lengths fit what the SME can hold.
    function automatic logic header_legal(input logic [7:0] str_len, input logic [7:0] pat_len);
        return (str_len <= 8'(MAX_STR_LEN)) && (pat_len <= 8'(MAX_PAT_LEN));
    endfunction

endpackage

// File: rtl/sme_result_reg.sv
// Result capture register with valid/ready hold; fields stay frozen until accepted.
module sme_result_reg #(
    parameter int unsigned JOB_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             load_timeout,
    input  logic             match,
    input  logic [4:0]       index,
    input  logic [JOB_W-1:0] job,
    input  logic             res_ready,
    output logic             res_valid,
    output logic             res_match,
    output logic [4:0]       res_index,
    output logic [JOB_W-1:0] res_job,
    output logic             res_timeout
);

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid   <= 1'b0;
            res_match   <= 1'b0;
            res_index   <= '0;
            res_job     <= '0;
            res_timeout <= 1'b0;
        end else if (load) begin
            res_valid   <= 1'b1;
            res_match   <= match & ~load_timeout;
            res_index   <= load_timeout ? 5'd0 : index;
            res_job     <= job;
            res_timeout <= load_timeout;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sme_job_loader.sv
// Walks a packed job list in byte memory, streams each job into the SME and
// hands every SME result (or timeout) downstream tagged with its job number.
module sme_job_loader
    import sme_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned JOB_W   = 6,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        chardata,
    output logic              isstring,
    output logic              ispattern,
    input  logic              sme_match,
    input  logic [4:0]        sme_match_index,
    input  logic              sme_valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_match,
    output logic [4:0]        res_index,
    output logic [JOB_W-1:0]  res_job,
    output logic              res_timeout,
    output logic              busy,
    output logic              done,
    output logic              err_len
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    // Wide enough for str_len + pat_len of a legal header (at most 40).
    localparam int unsigned LEN_W = 6;

    state_t            state;
    logic [7:0]        str_len;
    logic [LEN_W-1:0]  pat_len;
    logic [LEN_W-1:0]  issue_left;
    logic [LEN_W-1:0]  out_left;
    logic [CNT_W-1:0]  wait_cnt;
    logic [JOB_W-1:0]  job;

    logic              load_c;
    logic              load_timeout_c;
    logic              xfer_c;
    logic [LEN_W-1:0]  total_c;

    assign total_c = LEN_W'(str_len) + LEN_W'(mem_rdata);
    assign xfer_c  = res_valid & res_ready;

    // A real SME result beats the timeout when both land on the same cycle.
    always_comb begin
        load_c         = 1'b0;
        load_timeout_c = 1'b0;
        if (state == S_WAIT) begin
            if (sme_valid) begin
                load_c = 1'b1;
            end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                load_c         = 1'b1;
                load_timeout_c = 1'b1;
            end
        end
    end

    // Data addresses are issued one cycle ahead of the byte being presented,
    // so mem_addr always holds the last address issued for the current job.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            mem_addr   <= '0;
            chardata   <= '0;
            isstring   <= 1'b0;
            ispattern  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_len    <= 1'b0;
            str_len    <= '0;
            pat_len    <= '0;
            issue_left <= '0;
            out_left   <= '0;
            wait_cnt   <= '0;
            job        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RD_H0;
                        mem_addr <= '0;
                        job      <= '0;
                        busy     <= 1'b1;
                        err_len  <= 1'b0;
                    end
                end
                S_RD_H0: begin
                    mem_addr <= mem_addr + ADDR_W'(1);
                    state    <= S_RD_H1;
                end
                S_RD_H1: begin
                    str_len  <= mem_rdata;
                    mem_addr <= mem_addr + ADDR_W'(1);
                    state    <= S_CHK;
                end
                S_CHK: begin
                    pat_len    <= LEN_W'(mem_rdata);
                    issue_left <= '0;
                    if (mem_rdata == 8'd0) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (!header_legal(str_len, mem_rdata)) begin
                        err_len <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        if (total_c > LEN_W'(1)) begin
                            mem_addr   <= mem_addr + ADDR_W'(1);
                            issue_left <= total_c - LEN_W'(2);
                        end
                        if (str_len == 8'd0) begin
                            out_left <= LEN_W'(mem_rdata);
                            state    <= S_PAT;
                        end else begin
                            out_left <= LEN_W'(str_len);
                            state    <= S_STR;
                        end
                    end
                end
                S_STR, S_PAT: begin
                    chardata  <= mem_rdata;
                    isstring  <= (state == S_STR);
                    ispattern <= (state == S_PAT);
                    if (issue_left != '0) begin
                        mem_addr   <= mem_addr + ADDR_W'(1);
                        issue_left <= issue_left - LEN_W'(1);
                    end
                    out_left <= out_left - LEN_W'(1);
                    if (out_left == LEN_W'(1)) begin
                        if (state == S_STR) begin
                            out_left <= pat_len;
                            state    <= S_PAT;
                        end else begin
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    chardata  <= '0;
                    isstring  <= 1'b0;
                    ispattern <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (load_c) begin
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (xfer_c) begin
                        job      <= job + JOB_W'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                        state    <= S_RD_H0;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    sme_result_reg #(
        .JOB_W(JOB_W)
    ) u_result_reg (
        .clk          (clk),
        .reset        (reset),
        .load         (load_c),
        .load_timeout (load_timeout_c),
        .match        (sme_match),
        .index        (sme_match_index),
        .job          (job),
        .res_ready    (res_ready),
        .res_valid    (res_valid),
        .res_match    (res_match),
        .res_index    (res_index),
        .res_job      (res_job),
        .res_timeout  (res_timeout)
    );

endmodule

// File: tb/tb_sme_job_loader.sv
// Randomised scoreboard bench for sme_job_loader with a job-list reference model and SME model.
module tb_sme_job_loader;
    import sme_pkg::*;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned JOB_W   = 6;
    localparam int unsigned TIMEOUT = 255;
    localparam int unsigned MEM_SZ  = 1 << ADDR_W;

    typedef struct packed {
        logic             match;
        logic [4:0]       index;
        logic [JOB_W-1:0] job;
        logic             timeout;
    } res_t;

    typedef struct packed {
        logic       mute;
        logic [4:0] delay;
        logic       match;
        logic [4:0] index;
    } plan_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        chardata;
    logic              isstring, ispattern;
    logic              sme_match;
    logic [4:0]        sme_match_index;
    logic              sme_valid;
    logic              res_valid, res_ready, res_match, res_timeout;
    logic [4:0]        res_index;
    logic [JOB_W-1:0]  res_job;
    logic              busy, done, err_len;

    logic [7:0] mem [MEM_SZ];
    logic [9:0] exp_chars [$];
    res_t       exp_res [$];
    plan_t      plan [$];
    bit         exp_err;
    int         ready_mode;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem[mem_addr];

    sme_job_loader #(.ADDR_W(ADDR_W), .JOB_W(JOB_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .sme_match(sme_match), .sme_match_index(sme_match_index), .sme_valid(sme_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
        .res_index(res_index), .res_job(res_job), .res_timeout(res_timeout),
        .busy(busy), .done(done), .err_len(err_len)
    );

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: walk the job list as records and derive the expected byte stream and results.
    function automatic void build_model(input int mute_job);
        int p = 0;
        int job = 0;
        logic [7:0] h0, h1;
        plan_t pl;
        exp_chars.delete(); exp_res.delete(); plan.delete();
        exp_err = 1'b0;
        while (job < 200) begin
            h0 = mem[p % MEM_SZ];
            h1 = mem[(p + 1) % MEM_SZ];
            p += 2;
            if (h1 == 8'd0) break;
            if (h0 > 8'd32 || h1 > 8'd8) begin
                exp_err = 1'b1;
                break;
            end
            for (int i = 0; i < int'(h0); i++) exp_chars.push_back({2'b01, mem[(p + i) % MEM_SZ]});
            p += int'(h0);
            for (int i = 0; i < int'(h1); i++) exp_chars.push_back({2'b10, mem[(p + i) % MEM_SZ]});
            p += int'(h1);
            pl.mute  = (job == mute_job);
            pl.delay = 5'($urandom_range(0, 30));
            pl.match = 1'($urandom);
            pl.index = 5'($urandom);
            plan.push_back(pl);
            if (pl.mute) exp_res.push_back({1'b0, 5'd0, JOB_W'(job), 1'b1});
            else         exp_res.push_back({pl.match, pl.index, JOB_W'(job), 1'b0});
            job++;
        end
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < int'(MEM_SZ); i++) mem[i] = 8'd0;
    endtask

    task automatic gen_random(input int n_jobs, input int smax);
        int p = 0;
        int s, t;
        clear_mem();
        for (int j = 0; j < n_jobs; j++) begin
            s = $urandom_range(0, smax);
            t = $urandom_range(1, 8);
            mem[p] = 8'(s);
            mem[p + 1] = 8'(t);
            p += 2;
            for (int i = 0; i < s + t; i++) mem[p + i] = 8'($urandom);
            p += s + t;
        end
        mem[p] = 8'($urandom);
        mem[p + 1] = 8'd0;
    endtask

    task automatic pulse_start(input bit chk_clear);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk(busy == 1'b1, "busy_after_start", busy, 1);
        if (chk_clear) chk(err_len == 1'b0, "err_clear_on_start", err_len, 0);
    endtask

    task automatic finish_run();
        int n = 0;
        while (!done && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk(done == 1'b1, "done_seen", done, 1);
        chk(busy == 1'b0, "busy_at_done", busy, 0);
        chk(err_len == exp_err, "err_len", err_len, exp_err);
        chk(exp_res.size() == 0, "results_left", exp_res.size(), 0);
        chk(exp_chars.size() == 0, "chars_left", exp_chars.size(), 0);
        chk(plan.size() == 0, "sme_jobs_left", plan.size(), 0);
    endtask

    // SME model: answers each job after its gap cycle with the planned delay, or stays silent.
    initial begin : sme_model
        bit was_pat = 1'b0;
        bit pend = 1'b0;
        int cd = 0;
        plan_t pl;
        sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = 5'd0;
        forever begin
            @(negedge clk);
            sme_valid = 1'b0;
            sme_match = 1'($urandom);
            sme_match_index = 5'($urandom);
            if (reset) begin
                was_pat = 1'b0;
                pend = 1'b0;
            end else begin
                if (was_pat && !ispattern && !isstring) begin
                    if (plan.size() == 0) chk(1'b0, "sme_unplanned_job", 1, 0);
                    else begin
                        pl = plan.pop_front();
                        pend = !pl.mute;
                        cd = int'(pl.delay);
                    end
                end
                if (pend) begin
                    if (cd == 0) begin
                        sme_valid = 1'b1;
                        sme_match = pl.match;
                        sme_match_index = pl.index;
                        pend = 1'b0;
                    end else cd--;
                end
                was_pat = ispattern;
            end
        end
    end

    // Monitor: checks the byte stream, gap, timeout latency and result handshakes; drives res_ready.
    initial begin : monitor
        int cyc = 0, gap_cyc = 0, hold_cyc = 0;
        bit was_pat = 1'b0, prev_valid = 1'b0, expect_low = 1'b0, stable_ok = 1'b1;
        logic [12:0] snap;
        logic [ADDR_W-1:0] snap_addr;
        logic [9:0] e;
        res_t r;
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                was_pat = 1'b0; prev_valid = 1'b0; expect_low = 1'b0; hold_cyc = 0;
                res_ready = 1'b0;
                continue;
            end
            if (isstring || ispattern) begin
                if (exp_chars.size() == 0) chk(1'b0, "char_unexpected", {ispattern, isstring, chardata}, 0);
                else begin
                    e = exp_chars.pop_front();
                    chk({ispattern, isstring, chardata} == e, "char_stream", {ispattern, isstring, chardata}, e);
                end
            end
            if (was_pat && !ispattern && !isstring) begin
                gap_cyc = cyc;
                chk(chardata == 8'd0, "gap_chardata", chardata, 0);
            end
            was_pat = ispattern;
            if (expect_low) begin
                chk(!res_valid, "valid_drop_after_xfer", res_valid, 0);
                expect_low = 1'b0;
            end
            if (res_valid && !prev_valid) begin
                hold_cyc = 0;
                stable_ok = 1'b1;
                snap = {res_match, res_index, res_job, res_timeout};
                snap_addr = mem_addr;
                if (exp_res.size() > 0 && exp_res[0].timeout)
                    chk(cyc - gap_cyc == int'(TIMEOUT), "timeout_latency", cyc - gap_cyc, TIMEOUT);
            end
            if (res_valid) begin
                hold_cyc++;
                if ({res_match, res_index, res_job, res_timeout} != snap || mem_addr != snap_addr) stable_ok = 1'b0;
                case (ready_mode)
                    0: res_ready = 1'b1;
                    1: res_ready = ($urandom_range(0, 3) != 0);
                    default: res_ready = (hold_cyc > 10);
                endcase
            end else begin
                res_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom) : 1'b0;
            end
            if (res_valid && res_ready) begin
                if (exp_res.size() == 0) chk(1'b0, "result_unexpected", {res_match, res_index, res_job, res_timeout}, 0);
                else begin
                    r = exp_res.pop_front();
                    chk({res_match, res_index, res_job, res_timeout} == r, "result", {res_match, res_index, res_job, res_timeout}, r);
                end
                if (ready_mode == 2) chk(stable_ok && hold_cyc == 11, "hold_stable", hold_cyc, 11);
                expect_low = 1'b1;
            end
            prev_valid = res_valid;
        end
    end

    initial begin : main
        int n;
        reset = 1'b1; start = 1'b0; ready_mode = 0;
        clear_mem();
        repeat (3) @(negedge clk);
        chk({mem_addr, chardata, isstring, ispattern, res_valid, res_match, res_index, res_job,
             res_timeout, busy, done, err_len} == '0, "reset_outputs", chardata, 0);
        reset = 1'b0;

        // Directed two-job list, second job reuses the string.
        clear_mem();
        mem[0] = 8'd5; mem[1] = 8'd2;
        mem[2] = "a"; mem[3] = "b"; mem[4] = CH_SPACE; mem[5] = "c"; mem[6] = "d";
        mem[7] = CH_START; mem[8] = "c";
        mem[9] = 8'd0; mem[10] = 8'd3;
        mem[11] = "d"; mem[12] = CH_ANY; mem[13] = CH_END;
        build_model(-1);
        plan[0] = '{mute: 1'b0, delay: 5'd3, match: 1'b1, index: 5'd3};
        exp_res[0] = '{match: 1'b1, index: 5'd3, job: '0, timeout: 1'b0};
        ready_mode = 0;
        pulse_start(1'b0);
        repeat (3) @(negedge clk);
        chk(isstring == 1'b0, "latency_before_first", isstring, 0);
        @(negedge clk);
        chk(isstring == 1'b1, "latency_first_byte", isstring, 1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        finish_run();

        // Random job lists under random backpressure.
        ready_mode = 1;
        for (int it = 0; it < 3; it++) begin
            gen_random(5, 32);
            build_model(-1);
            pulse_start(1'b0);
            finish_run();
        end

        // Enough short jobs to wrap the job counter.
        ready_mode = 0;
        gen_random(70, 2);
        build_model(-1);
        pulse_start(1'b0);
        finish_run();

        // Downstream stalls for ten cycles per result.
        ready_mode = 2;
        gen_random(2, 10);
        build_model(-1);
        pulse_start(1'b0);
        finish_run();

        // Silent SME on the middle job.
        ready_mode = 1;
        gen_random(3, 12);
        build_model(1);
        pulse_start(1'b0);
        finish_run();

        // Illegal headers, then a clean run clears the flag.
        ready_mode = 0;
        clear_mem();
        mem[0] = 8'd33; mem[1] = 8'd2;
        build_model(-1);
        pulse_start(1'b0);
        finish_run();
        gen_random(1, 32);
        build_model(-1);
        pulse_start(1'b1);
        finish_run();
        clear_mem();
        mem[0] = 8'd3; mem[1] = 8'd9;
        build_model(-1);
        pulse_start(1'b0);
        finish_run();

        // Reset on the third string byte, then replay.
        gen_random(2, 8);
        mem[0] = 8'd6;
        for (int i = 0; i < 6 + int'(mem[1]); i++) mem[2 + i] = 8'($urandom);
        mem[8 + int'(mem[1])] = 8'd0;
        mem[9 + int'(mem[1])] = 8'd0;
        build_model(-1);
        pulse_start(1'b1);
        n = 0;
        while (n < 3) begin
            @(negedge clk);
            if (isstring) n++;
            if (done) break;
        end
        chk(n == 3, "third_string_byte_seen", n, 3);
        reset = 1'b1;
        @(negedge clk);
        chk({mem_addr, chardata, isstring, ispattern, res_valid, res_match, res_index, res_job,
             res_timeout, busy, done, err_len} == '0, "midjob_reset_outputs", {isstring, chardata}, 0);
        reset = 1'b0;
        build_model(-1);
        @(negedge clk);
        chk(busy == 1'b0, "idle_after_reset", busy, 0);
        pulse_start(1'b0);
        finish_run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sme_job_loader.md
Name: sme_job_loader

Overview:
- Upstream feeder for the string-matching engine (SME); runs a list of match jobs held in a byte-wide job memory.
- For each job it streams string and pattern bytes using the SME isstring/ispattern framing, then waits for the SME valid pulse.
- Each SME result is held in a result register and handed downstream through a valid/ready handshake, tagged with its job number.

Parameters:
- ADDR_W, 10, job memory address width in bits.
- JOB_W, 6, job counter width in bits; the job count wraps modulo 2^JOB_W.
- TIMEOUT, 255, maximum number of cycles to wait for sme_valid after a job's gap cycle.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; starts processing at address 0; ignored while busy
- mem_addr  out  ADDR_W  job memory read address
- mem_rdata  in  8  job memory data; valid exactly 1 cycle after mem_addr
- chardata  out  8  byte sent to the SME
- isstring  out  1  chardata is a string byte
- ispattern  out  1  chardata is a pattern byte
- sme_match  in  1  SME match flag; sampled when sme_valid=1
- sme_match_index  in  5  SME match index; sampled when sme_valid=1
- sme_valid  in  1  SME result strobe, one cycle wide
- res_valid  out  1  result available downstream
- res_ready  in  1  downstream accepts the result
- res_match  out  1  captured match flag
- res_index  out  5  captured match index
- res_job  out  JOB_W  job number of this result
- res_timeout  out  1  result was produced by timeout, not by the SME
- busy  out  1  high from start acceptance until DONE
- done  out  1  one-cycle pulse on entering IDLE from DONE
- err_len  out  1  sticky illegal-header flag; cleared on the next accepted start

Behaviour:
- Job record layout: H0 = str_len, H1 = pat_len, then str_len string bytes, then pat_len pattern bytes. Records are packed back to back.
  - H1 == 0 terminates the job list.
  - str_len == 0 means reuse the previous string: no string bytes are sent.
  - Legal ranges: str_len 0..32, pat_len 1..8 (pattern characters include ^ $ .).
- Reset: every output is 0, mem_addr = 0, state IDLE, err_len cleared.
  - A reset asserted mid-job aborts immediately. The SME is also reset by the same signal.
- States: IDLE, RD_H0, RD_H1, CHK, STR, PAT, GAP, WAIT, HOLD, DONE.
  - IDLE: on start, go to RD_H0 with address pointer = 0, job = 0, busy = 1.
  - RD_H0 and RD_H1: issue the address and latch the returned byte one cycle later. The pointer increments once per byte.
  - CHK: if pat_len == 0, go to DONE. If str_len > 32 or pat_len > 8, set err_len and go to DONE. Otherwise go to STR, or to PAT if str_len == 0.
  - STR: issue one address per cycle. Each returned byte appears on the next clock as a registered chardata with isstring = 1. isstring is high for exactly str_len consecutive cycles.
  - PAT: same as STR with ispattern = 1, for exactly pat_len cycles. PAT follows STR with no idle cycle; the read pipeline is primed during the last string cycle.
  - isstring and ispattern are never high together.
  - GAP: one cycle with isstring = ispattern = 0 and chardata = 0. Then go to WAIT.
  - WAIT: a cycle counter starts at 0.
    - When sme_valid = 1, capture sme_match and sme_match_index into res_*, set res_timeout = 0, res_valid = 1, go to HOLD.
    - When the counter reaches TIMEOUT, set res_match = 0, res_index = 0, res_timeout = 1, res_valid = 1, go to HOLD.
    - sme_valid on the same cycle the counter reaches TIMEOUT: sme_valid takes priority.
  - HOLD: res_* are held stable while res_valid = 1 and res_ready = 0.
    - When res_valid & res_ready: res_valid = 0, job increments (wraps), go to RD_H0 at the current pointer.
    - If res_ready was already high on HOLD entry, the transfer completes in that cycle.
    - sme_valid arriving outside WAIT is ignored.
  - DONE: busy = 0, done pulses for one cycle, return to IDLE.
- Pointer wraps modulo 2^ADDR_W with no error.
- start during busy has no effect.
- Latency: the first string byte reaches chardata 4 cycles after start is sampled.

Decomposition:
- Shared package sme_pkg holds:
  - constants MAX_STR_LEN = 32, MAX_PAT_LEN = 8;
  - the characters CH_START = 8'h5E, CH_END = 8'h24, CH_ANY = 8'h2E, CH_SPACE = 8'h20;
  - the state enum.
- One natural sub-module, sme_result_reg: the result capture register plus the valid/ready hold logic. The FSM stays in the top.

Test Plan:
- Memory {5,2,"ab cd","^c",0,0}, SME model reports match at index 3 → isstring high for 5 cycles then ispattern for 2, one gap cycle; result res_match = 1, res_index = 3, res_job = 0, then done after the terminator.
- Second job with H0 = 0, H1 = 3, "d.$" → no isstring cycles, ispattern high for 3 cycles; result tagged res_job = 1.
- Hold res_ready = 0 for 10 cycles after res_valid → res_* stable throughout, no memory reads issued; transfer completes in the cycle res_ready rises.
- SME model never asserts sme_valid → exactly TIMEOUT cycles after GAP, res_timeout = 1 and res_match = 0; the next job proceeds.
- Header {33,2} → err_len = 1, no isstring or ispattern cycles, done pulses; a later start clears err_len.
- Assert reset during the 3rd string byte → next cycle all outputs are 0 and state is IDLE; a fresh start replays job 0 correctly.
